// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and sizing helpers for the show-ahead FIFO burst reader.
package fifo_burst_reader_pkg;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = S_IDLE,
    BURST = S_BURST
  } state_e;

  // Beat and length counters must be able to hold BURST_LEN itself.
  function automatic int unsigned cnt_width(input int unsigned burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus downstream valid/ready stream, grouped for the burst reader.
interface fifo_burst_reader_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 5
) ();
  import fifo_burst_reader_pkg::*;

  logic [DWIDTH-1:0] q_i;
  logic              empty_i;
  logic [AWIDTH:0]   usedw_i;
  logic              rdreq_o;
  logic [DWIDTH-1:0] data_o;
  logic              valid_o;
  logic              ready_i;
  logic              sop_o;
  logic              eop_o;

  modport master (
    input  q_i, empty_i, usedw_i, ready_i,
    output rdreq_o, data_o, valid_o, sop_o, eop_o
  );

  modport slave (
    output q_i, empty_i, usedw_i, ready_i,
    input  rdreq_o, data_o, valid_o, sop_o, eop_o
  );

endinterface

// File: rtl/fifo_out_reg.sv
// One-entry valid/ready output register carrying data and sop/eop framing.
module fifo_out_reg
  import fifo_burst_reader_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              load_i,
  input  logic [DWIDTH-1:0] d_i,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              sop_o,
  output logic              eop_o,
  output logic              free_o
);

  logic              valid_q, valid_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;

  assign free_o = !valid_q || ready_i;

  // Loads only arrive when free_o is high, so a load always overwrites safely.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = d_i;
      sop_d   = sop_i;
      eop_d   = eop_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read master for a show-ahead FIFO; pops fixed or flushed-length bursts.
// Optional burst/short-burst counters enabled by FIFO_BURST_READER_STATS_EN.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DWIDTH    = 16,
  parameter int AWIDTH    = 5,
  parameter int BURST_LEN = 8
) (
  input  logic                clk_i,
  input  logic                srst_i,
  fifo_burst_reader_if.master bus,
  input  logic                flush_i,
  output logic                busy_o
`ifdef FIFO_BURST_READER_STATS_EN
  ,
  output logic [15:0]         burst_cnt_o,
  output logic [15:0]         short_cnt_o
`endif
);

  localparam int unsigned      CW     = cnt_width(BURST_LEN);
  localparam logic [AWIDTH:0]  BL_LVL = (AWIDTH + 1)'(BURST_LEN);
  localparam logic [CW-1:0]    BL_CNT = CW'(BURST_LEN);

  state_e        state_q, state_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] beat_q, beat_d;
  logic          free;
  logic          pop;
  logic          last;
  logic          start_short;

  assign pop  = (state_q == BURST) && !bus.empty_i && free;
  assign last = (beat_q == len_q - CW'(1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    beat_d      = beat_q;
    start_short = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.usedw_i >= BL_LVL) begin
          state_d = BURST;
          len_d   = BL_CNT;
        end else if (flush_i && (bus.usedw_i != '0) && !bus.empty_i) begin
          // usedw_i < BURST_LEN here, so it fits in the counter width
          state_d     = BURST;
          len_d       = bus.usedw_i[CW-1:0];
          start_short = 1'b1;
        end
      end
      BURST: begin
        if (pop) begin
          if (last) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

  fifo_out_reg #(
    .DWIDTH (DWIDTH)
  ) u_out_reg (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .load_i  (pop),
    .d_i     (bus.q_i),
    .sop_i   (beat_q == '0),
    .eop_i   (last),
    .ready_i (bus.ready_i),
    .valid_o (bus.valid_o),
    .data_o  (bus.data_o),
    .sop_o   (bus.sop_o),
    .eop_o   (bus.eop_o),
    .free_o  (free)
  );

  assign bus.rdreq_o = pop;
  assign busy_o      = (state_q == BURST);

`ifdef FIFO_BURST_READER_STATS_EN
  logic [15:0] burst_cnt_q, burst_cnt_d;
  logic [15:0] short_cnt_q, short_cnt_d;

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    short_cnt_d = short_cnt_q;
    if (bus.valid_o && bus.ready_i && bus.eop_o) burst_cnt_d = burst_cnt_q + 16'd1;
    if (start_short) short_cnt_d = short_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      burst_cnt_q <= '0;
      short_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      short_cnt_q <= short_cnt_d;
    end
  end

  assign burst_cnt_o = burst_cnt_q;
  assign short_cnt_o = short_cnt_q;
`else
  logic unused_start_short;
  assign unused_start_short = start_short;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: FIFO model, directed bursts, stream monitor.
module tb_fifo_burst_reader;
  import fifo_burst_reader_pkg::*;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int BL = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  logic clk = 1'b0;
  logic srst = 1'b1;
  logic flush = 1'b0;
  logic busy;
`ifdef FIFO_BURST_READER_STATS_EN
  logic [15:0] burst_cnt, short_cnt;
`endif

  fifo_burst_reader_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  fifo_burst_reader #(
    .DWIDTH    (DW),
    .AWIDTH    (AW),
    .BURST_LEN (BL)
  ) dut (
    .clk_i       (clk),
    .srst_i      (srst),
    .bus         (bus),
    .flush_i     (flush),
    .busy_o      (busy)
`ifdef FIFO_BURST_READER_STATS_EN
    ,
    .burst_cnt_o (burst_cnt),
    .short_cnt_o (short_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model
  logic [DW-1:0] mem [0:255];
  logic [7:0]    wr_ptr = '0;
  logic [7:0]    rd_ptr = '0;
  logic          force_empty = 1'b0;
  logic          pop_pend = 1'b0;

  always_comb begin
    bus.empty_i = (wr_ptr == rd_ptr) || force_empty;
    bus.usedw_i = (AW + 1)'(wr_ptr - rd_ptr);
    bus.q_i     = mem[rd_ptr];
  end

  always @(posedge clk) if (pop_pend) rd_ptr <= rd_ptr + 8'd1;

  beat_t       exp_q[$];
  int unsigned xfer_cyc[$];
  int unsigned pop_cyc[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int unsigned eop_seen = 0;

  // Stream monitor: pops scoreboard on each transfer, checks hold stability and pop legality
  initial begin
    logic  hold_prev;
    beat_t prev, act, e;
    hold_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cyc++;
      pop_pend = bus.rdreq_o;
      act = '{data: bus.data_o, sop: bus.sop_o, eop: bus.eop_o};
      if (bus.rdreq_o) begin
        pop_cyc.push_back(cyc);
        checks++;
        if (bus.empty_i || (bus.valid_o && !bus.ready_i)) begin
          failures++;
          $display("FAIL rdreq_legal: cyc=%0d empty=%0b valid=%0b ready=%0b, required no pop", cyc, bus.empty_i, bus.valid_o, bus.ready_i);
        end
      end
      if (hold_prev) begin
        checks++;
        if (!bus.valid_o || act !== prev) begin
          failures++;
          $display("FAIL hold_stable: cyc=%0d valid=%0b beat=%h, required valid=1 beat=%h", cyc, bus.valid_o, act, prev);
        end
      end
      hold_prev = !srst && bus.valid_o && !bus.ready_i;
      prev = act;
      if (bus.valid_o && bus.ready_i) begin
        xfer_cyc.push_back(cyc);
        if (bus.eop_o) eop_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected: cyc=%0d got data=%h sop=%0b eop=%0b, required none", cyc, act.data, act.sop, act.eop);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL beat: cyc=%0d got data=%h sop=%0b eop=%0b, required data=%h sop=%0b eop=%0b", cyc, act.data, act.sop, act.eop, e.data, e.sop, e.eop);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic expect_beat(input logic [DW-1:0] w, input logic s, input logic e);
    exp_q.push_back('{data: w, sop: s, eop: e});
  endtask

  // Pushes n words base..base+n-1 and their expected framing for bursts of len
  task automatic push_bursts(input logic [DW-1:0] base, input int unsigned n, input int unsigned len);
    for (int unsigned i = 0; i < n; i++) begin
      push_word(base + DW'(i));
      expect_beat(base + DW'(i), (i % len) == 0, (i % len) == len - 1);
    end
  endtask

  task automatic wait_drain(input string name);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_pops(input int unsigned n, input string name);
    int unsigned seen, t;
    seen = 0;
    t = 0;
    while (seen < n && t < 200) begin
      @(negedge clk);
      if (bus.rdreq_o) seen++;
      t++;
    end
    checks++;
    if (seen < n) begin
      failures++;
      $display("FAIL %s_pops: got %0d pops, required %0d", name, seen, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned x0, p0, e0;
    logic [3:0] pat;
    pat = 4'b1001;
    bus.ready_i = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_sop",   32'(bus.sop_o),   32'd0);
    chk("rst_eop",   32'(bus.eop_o),   32'd0);
    chk("rst_data",  32'(bus.data_o),  32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_rdreq", 32'(bus.rdreq_o), 32'd0);
    @(posedge clk); #1 srst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Full burst, ready held high
    x0 = xfer_cyc.size();
    push_bursts(16'h0001, 8, BL);
    @(negedge clk);
    chk("t1_idle_busy",  32'(busy),        32'd0);
    chk("t1_idle_rdreq", 32'(bus.rdreq_o), 32'd0);
    @(negedge clk);
    chk("t1_busy",  32'(busy),        32'd1);
    chk("t1_rdreq", 32'(bus.rdreq_o), 32'd1);
    wait_drain("t1");
    chk("t1_back_to_back", xfer_cyc[x0 + 7] - xfer_cyc[x0], 32'd7);
    @(negedge clk);
    chk("t1_end_busy",  32'(busy),        32'd0);
    chk("t1_end_valid", 32'(bus.valid_o), 32'd0);
`ifdef FIFO_BURST_READER_STATS_EN
    chk("t1_burst_cnt", 32'(burst_cnt), 32'd1);
`endif

    // Flush-driven short burst
    @(posedge clk); #1;
    push_bursts(16'h00A0, 3, 3);
    flush = 1'b1;
    wait_drain("t2");
    flush = 1'b0;
    @(negedge clk);
    chk("t2_end_busy", 32'(busy), 32'd0);
`ifdef FIFO_BURST_READER_STATS_EN
    chk("t2_short_cnt", 32'(short_cnt), 32'd1);
    chk("t2_burst_cnt", 32'(burst_cnt), 32'd2);
`endif

    // Backpressure pattern 1,0,0,1 repeating
    @(posedge clk); #1;
    push_bursts(16'h0060, 8, BL);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
      bus.ready_i = pat[i % 4];
      @(posedge clk); #1;
    end
    bus.ready_i = 1'b1;
    wait_drain("t3");

    // Two back-to-back bursts from a level of 16
    @(posedge clk); #1;
    p0 = pop_cyc.size();
    e0 = eop_seen;
    push_bursts(16'h0010, 16, BL);
    wait_drain("t4");
    @(negedge clk);
    chk("t4_pops", pop_cyc.size() - p0, 32'd16);
    if (pop_cyc.size() - p0 >= 16) begin
      chk("t4_burst1_span", pop_cyc[p0 + 7] - pop_cyc[p0], 32'd7);
      chk("t4_gap", pop_cyc[p0 + 8] - pop_cyc[p0 + 7], 32'd2);
    end
    chk("t4_eops", eop_seen - e0, 32'd2);

    // Reset after the 4th pop: five words popped, four delivered, no eop
    @(posedge clk); #1;
    for (int unsigned i = 0; i < 8; i++) push_word(16'h0030 + DW'(i));
    for (int unsigned i = 0; i < 4; i++) expect_beat(16'h0030 + DW'(i), i == 0, 1'b0);
    wait_pops(4, "t5");
    @(posedge clk); #1 srst = 1'b1;
    @(posedge clk); #1 srst = 1'b0;
    @(negedge clk);
    chk("t5_valid", 32'(bus.valid_o), 32'd0);
    chk("t5_busy",  32'(busy),        32'd0);
    chk("t5_rdreq", 32'(bus.rdreq_o), 32'd0);
    chk("t5_exp_left", exp_q.size(), 32'd0);
    chk("t5_level", 32'(bus.usedw_i), 32'd3);
    @(posedge clk); #1;
    for (int unsigned i = 0; i < 5; i++) push_word(16'h0040 + DW'(i));
    for (int unsigned i = 0; i < 3; i++) expect_beat(16'h0035 + DW'(i), i == 0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) expect_beat(16'h0040 + DW'(i), 1'b0, i == 4);
    wait_drain("t5");

    // Empty stall for 3 clk after beat 4
    @(posedge clk); #1;
    push_bursts(16'h0050, 8, BL);
    wait_pops(4, "t6");
    @(posedge clk); #1 force_empty = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_stall_rdreq", 32'(bus.rdreq_o), 32'd0);
      chk("t6_stall_busy",  32'(busy),        32'd1);
    end
    @(posedge clk); #1 force_empty = 1'b0;
    wait_drain("t6");
    @(negedge clk);
    chk("t6_end_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side master for the team's show-ahead FIFO: monitors fill level, pops words in fixed-length bursts and presents them as a registered valid/ready stream with start/end-of-packet framing. Sits between the FIFO read port (q, empty, usedw, rdreq) and a downstream packet consumer. A flush input forces out a short final burst of whatever remains.

Parameters:
DWIDTH, 16, data word width (matches FIFO DWIDTH)
AWIDTH, 5, FIFO address width; usedw_i is AWIDTH+1 bits
BURST_LEN, 8, words per full burst; legal range 1..2**AWIDTH

Ports:
clk_i  in  1  clock
srst_i  in  1  synchronous active-high reset
q_i  in  DWIDTH  FIFO show-ahead head word, valid when empty_i=0
empty_i  in  1  FIFO empty
usedw_i  in  AWIDTH+1  FIFO fill level
rdreq_o  out  1  FIFO pop, combinational
flush_i  in  1  level; permits a short burst when usedw_i < BURST_LEN
data_o  out  DWIDTH  stream data, registered
valid_o  out  1  stream valid
ready_i  in  1  stream ready
sop_o  out  1  first beat of burst, qualified by valid_o
eop_o  out  1  last beat of burst, qualified by valid_o
busy_o  out  1  FSM not in IDLE

Behaviour:
- Clock is clk_i; srst_i is a synchronous, active-high reset. On reset: state IDLE, valid_o=0, sop_o=0, eop_o=0, data_o=0, busy_o=0, beat counter=0, latched length=0. Reset mid-burst abandons the burst; no eop is emitted and the already-popped words are lost.
- FSM states: IDLE, BURST.
- IDLE -> BURST when usedw_i >= BURST_LEN: latch len=BURST_LEN. Otherwise, IDLE -> BURST when flush_i=1 and usedw_i!=0 and empty_i=0: latch len=usedw_i. Full-length start has priority. len register is clog2(BURST_LEN+1) bits wide.
- The decision is registered. No pop occurs in the IDLE cycle; the first pop can happen in the first BURST cycle.
- In BURST: rdreq_o = !empty_i && (!valid_o || ready_i). rdreq_o is 0 in IDLE. No pop is ever issued while empty_i=1.
- Each pop loads data_o<=q_i and sets valid_o=1 on the next edge (latency 1 clk from pop to valid).
  - sop_o<=(beat==0).
  - eop_o<=(beat==len-1).
  - beat increments.
- When a stream beat transfers (valid_o && ready_i) and there is no pop in the same cycle, valid_o clears.
- While valid_o=1 and ready_i=0, data_o, sop_o and eop_o hold stable.
- Pop and transfer in the same cycle give back-to-back beats: 1 word/clk sustained.
- Last pop (beat==len-1): beat<=0 and state<=IDLE on the same edge.
  - The final beat may still be pending in the output register while in IDLE. Its valid/ready completes normally.
  - The next burst's first pop waits until that register is free.
- Minimum gap between the last pop of one burst and the first pop of the next is 1 clk.
- If empty_i rises mid-burst, pops stall and the FSM stays in BURST until data returns. There is no timeout.
- flush_i is sampled only in IDLE. Deasserting it mid-burst does not shorten the burst.
- busy_o = (state==BURST).

Optional Feature:
Macro FIFO_BURST_READER_STATS_EN.
- When defined, add the following output ports:
  - burst_cnt_o (16 b): increments on each transferred eop beat, wraps 0xFFFF->0, reset 0.
  - short_cnt_o (16 b): increments on bursts started with len<BURST_LEN, same wrap and reset.
- When undefined, these ports and their counters do not exist. All other behaviour is identical.

Decomposition:
- Package fifo_burst_reader_pkg:
  - state enum type (IDLE, BURST).
  - localparam function for the beat/len counter width, clog2(BURST_LEN+1).
- Sub-module fifo_out_reg: a 1-entry valid/ready output register holding data, sop and eop.
  - Inputs: load, d, sop, eop.
  - Outputs: valid, data, sop, eop, and a free flag = !valid || ready.
  - The FSM and counters stay in the top.

Test Plan:
- Fill FIFO with 8 words 0x0001..0x0008 (usedw_i=8), ready_i=1.
  - Expect busy_o 1 clk later, 8 consecutive valid beats 0x0001..0x0008.
  - sop_o on 0x0001, eop_o on 0x0008, then return to IDLE.
- usedw_i=3, flush_i=1, words 0xA0..0xA2.
  - Expect a 3-beat burst: sop on 0xA0, eop on 0xA2.
  - short_cnt_o=1 with macro defined.
- Full burst with ready_i toggling 1,0,0,1,...
  - data_o and framing stable during ready_i=0, no words dropped or duplicated.
  - rdreq_o pulses only when !valid_o || ready_i.
- usedw_i=16 with ready_i=1.
  - Two 8-beat bursts, exactly 1-clk gap between last pop and next pop, 2 eop beats.
- Assert srst_i after the 4th pop of a burst.
  - Next cycle: valid_o=0, busy_o=0, rdreq_o=0.
  - Refill to 8: a fresh burst starting with sop.
- empty_i forced 1 for 3 clk mid-burst (beat 4).
  - rdreq_o=0 during the stall; burst resumes with beat 5; eop still on beat 8.
